// File: rtl/load_store_unit.sv
// load_store_unit: RV32I byte/half/word load-store sequencer with alignment checks, lane steering and load extension
module load_store_unit #(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_misaligned,
    output logic        rsp_error,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_byte_enable,
    input  logic [31:0] mem_rdata,
    input  logic        mem_resp
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    state_t      state, state_n;
    logic        wr_q;
    logic [2:0]  f3_q;
    logic [1:0]  lane_q;
    logic [31:0] wait_cnt;
    logic        illegal, misaligned, fault, timeout;
    logic [3:0]  store_be;
    logic [31:0] store_data, load_ext;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    // funct3[1:0] encodes access size for every legal request
    assign illegal    = (req_funct3[1:0] == 2'b11) | (req_funct3[2] & (req_write | req_funct3[1]));
    assign misaligned = !illegal & (((req_funct3[1:0] == 2'b01) & req_addr[0]) |
                                    ((req_funct3[1:0] == 2'b10) & (req_addr[1:0] != 2'b00)));
    assign fault      = illegal | misaligned;
    assign store_be   = req_funct3[1:0] == 2'b00 ? 4'b0001 << req_addr[1:0] :
                        req_funct3[1:0] == 2'b01 ? 4'b0011 << req_addr[1:0] : 4'b1111;
    assign store_data = req_funct3[1:0] == 2'b00 ? {24'b0, req_wdata[7:0]} << {req_addr[1:0], 3'b000} :
                        req_funct3[1:0] == 2'b01 ? {16'b0, req_wdata[15:0]} << {req_addr[1], 4'b0000} :
                        req_wdata;
    assign ld_byte    = mem_rdata[{lane_q, 3'b000} +: 8];
    assign ld_half    = mem_rdata[{lane_q[1], 4'b0000} +: 16];
    assign load_ext   = f3_q == 3'b000 ? {{24{ld_byte[7]}}, ld_byte} :
                        f3_q == 3'b001 ? {{16{ld_half[15]}}, ld_half} :
                        f3_q == 3'b100 ? {24'b0, ld_byte} :
                        f3_q == 3'b101 ? {16'b0, ld_half} : mem_rdata;
    assign timeout    = (MAX_WAIT != 0) && (wait_cnt + 32'd1 == MAX_WAIT);
    assign req_ready  = state == IDLE;
    always_comb begin
        state_n = state == IDLE   ? (req_valid ? (fault ? DONE : ACCESS) : IDLE) :
                  state == ACCESS ? ((mem_resp || timeout) ? DONE : ACCESS) : IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            wr_q            <= 1'b0;
            f3_q            <= 3'b000;
            lane_q          <= 2'b00;
            wait_cnt        <= 32'd0;
            rsp_valid       <= 1'b0;
            rsp_rdata       <= 32'd0;
            rsp_misaligned  <= 1'b0;
            rsp_error       <= 1'b0;
            mem_read        <= 1'b0;
            mem_write       <= 1'b0;
            mem_address     <= 32'd0;
            mem_wdata       <= 32'd0;
            mem_byte_enable <= 4'b0000;
        end else begin
            state     <= state_n;
            rsp_valid <= state_n == DONE;
            if (state == IDLE && req_valid) begin
                wr_q     <= req_write;
                f3_q     <= req_funct3;
                lane_q   <= req_addr[1:0];
                wait_cnt <= 32'd0;
                if (fault) begin
                    rsp_rdata      <= 32'd0;
                    rsp_misaligned <= misaligned;
                    rsp_error      <= illegal;
                end else begin
                    mem_read        <= !req_write;
                    mem_write       <= req_write;
                    mem_address     <= {req_addr[31:2], 2'b00};
                    mem_wdata       <= req_write ? store_data : 32'd0;
                    mem_byte_enable <= req_write ? store_be : 4'b1111;
                end
            end else if (state == ACCESS) begin
                if (mem_resp || timeout) begin
                    mem_read       <= 1'b0;
                    mem_write      <= 1'b0;
                    rsp_rdata      <= (mem_resp && !wr_q) ? load_ext : 32'd0;
                    rsp_misaligned <= 1'b0;
                    rsp_error      <= !mem_resp;
                end else begin
                    wait_cnt <= wait_cnt + 32'd1;
                end
            end
        end
    end
endmodule
